// File: rtl/mips_pkg.sv
// Shared constants and write-port FSM state encoding for the MIPS register file.
package mips_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bitmap: decode marks producers busy, writeback commits clear them.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int AW   = mips_pkg::AW,
    parameter int NREG = mips_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        // Set is applied after clear: a same-index set is a newer producer still outstanding.
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking '=' stays in always_comb.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wport.sv
// General-purpose register file with a four-phase write-port responder,
// two combinational read ports and a busy scoreboard.
module regfile_wport
    import mips_pkg::*;
#(
    parameter int DW   = mips_pkg::DW,
    parameter int AW   = mips_pkg::AW,
    parameter int NREG = mips_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_we,
    input  logic [AW-1:0]   wr_idx,
    input  logic [DW-1:0]   wr_data,
    output logic            reg_wack,
    input  logic [AW-1:0]   raddr_a,
    output logic [DW-1:0]   rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [DW-1:0]   rdata_b,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_idx,
    output logic [NREG-1:0] busy,
    output logic [15:0]     wr_count
);

    wr_state_e      state_q;
    logic           wack_q;
    logic [15:0]    wr_count_q;
    logic [DW-1:0]  regs_q [NREG];
    logic           commit;

    // A write commits exactly once, on the edge that first sees reg_we in IDLE.
    assign commit = (state_q == IDLE) && reg_we;

    // NOTE: the array is reset explicitly because a reset must also wipe already-committed data;
    // this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wack_q     <= 1'b0;
            wr_count_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (reg_we) begin
                        if (wr_idx != '0) begin
                            regs_q[wr_idx] <= wr_data;
                        end
                        wr_count_q <= wr_count_q + 16'd1;
                        wack_q     <= 1'b1;
                        state_q    <= ACK;
                    end
                end
                ACK: begin
                    if (!reg_we) begin
                        wack_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    wack_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata_a  = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b  = (raddr_b == '0) ? '0 : regs_q[raddr_b];
    assign reg_wack = wack_q;
    assign wr_count = wr_count_q;

    regfile_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (busy_set),
        .set_idx (busy_idx),
        .clr_en  (commit),
        .clr_idx (wr_idx),
        .busy    (busy)
    );

endmodule

// File: tb/tb_regfile_wport.sv
// Directed self-checking bench for regfile_wport: handshake, r0, scoreboard, reset.
module tb_regfile_wport;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clk;
    logic            rst;
    logic            reg_we;
    logic [AW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic            reg_wack;
    logic [AW-1:0]   raddr_a;
    logic [DW-1:0]   rdata_a;
    logic [AW-1:0]   raddr_b;
    logic [DW-1:0]   rdata_b;
    logic            busy_set;
    logic [AW-1:0]   busy_idx;
    logic [NREG-1:0] busy;
    logic [15:0]     wr_count;

    int checks = 0;
    int errors = 0;

    regfile_wport #(
        .DW   (DW),
        .AW   (AW),
        .NREG (NREG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reg_we   (reg_we),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .reg_wack (reg_wack),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .busy_set (busy_set),
        .busy_idx (busy_idx),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        reg_we   = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        raddr_a  = '0;
        raddr_b  = '0;
        busy_set = 1'b0;
        busy_idx = '0;
        repeat (3) step();
        rst     = 1'b1;
        raddr_a = 5'd5;
        raddr_b = 5'd31;
        #1;
        check("reset_rdata_a", 64'(rdata_a), 64'h0);
        check("reset_rdata_b", 64'(rdata_b), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_wack", 64'(reg_wack), 64'h0);
        check("reset_count", 64'(wr_count), 64'h0);

        // Basic handshake to r7
        reg_we  = 1'b1;
        wr_idx  = 5'd7;
        wr_data = 32'hDEADBEEF;
        raddr_a = 5'd7;
        #1;
        check("no_bypass", 64'(rdata_a), 64'h0);
        step();
        check("basic_wack", 64'(reg_wack), 64'h1);
        check("basic_rdata", 64'(rdata_a), 64'hDEADBEEF);
        check("basic_count", 64'(wr_count), 64'h1);
        wr_data = 32'hCAFEF00D;
        repeat (3) step();
        check("hold_count", 64'(wr_count), 64'h1);
        check("hold_wack", 64'(reg_wack), 64'h1);
        check("hold_rdata", 64'(rdata_a), 64'hDEADBEEF);
        reg_we = 1'b0;
        #1;
        check("drop_wack_pre", 64'(reg_wack), 64'h1);
        step();
        check("drop_wack", 64'(reg_wack), 64'h0);

        // r0 write is acknowledged and counted but discarded
        reg_we  = 1'b1;
        wr_idx  = 5'd0;
        wr_data = 32'h12345678;
        raddr_b = 5'd0;
        step();
        check("r0_wack", 64'(reg_wack), 64'h1);
        check("r0_count", 64'(wr_count), 64'h2);
        check("r0_rdata", 64'(rdata_b), 64'h0);
        reg_we = 1'b0;
        step();
        check("r0_wack_low", 64'(reg_wack), 64'h0);

        // Scoreboard set then commit-clear on r9
        busy_set = 1'b1;
        busy_idx = 5'd9;
        step();
        busy_set = 1'b0;
        check("busy_set9", 64'(busy), 64'h200);
        reg_we  = 1'b1;
        wr_idx  = 5'd9;
        wr_data = 32'h55;
        raddr_a = 5'd9;
        step();
        check("busy_clr9", 64'(busy), 64'h0);
        check("r9_rdata", 64'(rdata_a), 64'h55);
        check("r9_count", 64'(wr_count), 64'h3);
        reg_we = 1'b0;
        step();

        // busy[0] never sets
        busy_set = 1'b1;
        busy_idx = 5'd0;
        step();
        busy_set = 1'b0;
        check("busy_r0", 64'(busy), 64'h0);

        // Same-index set and commit: set wins
        busy_set = 1'b1;
        busy_idx = 5'd4;
        reg_we   = 1'b1;
        wr_idx   = 5'd4;
        wr_data  = 32'hA5A5A5A5;
        step();
        busy_set = 1'b0;
        check("busy_same", 64'(busy), 64'h10);
        check("same_count", 64'(wr_count), 64'h4);
        reg_we = 1'b0;
        step();

        // Different indices in one cycle: clear r4, set r6
        busy_set = 1'b1;
        busy_idx = 5'd6;
        reg_we   = 1'b1;
        wr_idx   = 5'd4;
        wr_data  = 32'h0BADF00D;
        raddr_b  = 5'd4;
        step();
        busy_set = 1'b0;
        check("busy_diff", 64'(busy), 64'h40);
        check("r4_rdata", 64'(rdata_b), 64'h0BADF00D);
        reg_we = 1'b0;
        step();

        // Data change while in ACK must not re-commit
        reg_we  = 1'b1;
        wr_idx  = 5'd3;
        wr_data = 32'h11;
        raddr_a = 5'd3;
        step();
        wr_data = 32'h22;
        step();
        check("ack_rdata", 64'(rdata_a), 64'h11);
        check("ack_count", 64'(wr_count), 64'h6);
        check("ack_wack", 64'(reg_wack), 64'h1);

        // Asynchronous reset mid-handshake, reg_we held through release
        rst = 1'b0;
        #1;
        check("mid_rst_wack", 64'(reg_wack), 64'h0);
        check("mid_rst_r3", 64'(rdata_a), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_count", 64'(wr_count), 64'h0);
        step();
        check("in_rst_r3", 64'(rdata_a), 64'h0);
        rst = 1'b1;
        #1;
        check("release_wack", 64'(reg_wack), 64'h0);
        step();
        check("post_rst_wack", 64'(reg_wack), 64'h1);
        check("post_rst_r3", 64'(rdata_a), 64'h22);
        check("post_rst_count", 64'(wr_count), 64'h1);
        reg_we = 1'b0;
        step();
        check("post_rst_wack_low", 64'(reg_wack), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
